// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: PC-stage handshake, imem request/response, decode output.
// slave is the queue's own view; master is the surrounding pipeline / memory.
interface instr_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            pc_valid;
  logic [XLEN-1:0] pc_addr;
  logic            pc_ready;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_ready;

  modport slave (
    input  pc_valid, pc_addr, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport master (
    output pc_valid, pc_addr, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  pc_ready, imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order responses into a {pc,instr} FIFO.
// Optional IFQ_BYPASS_EN: a kept response into an empty FIFO is presented to decode in the same cycle.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  instr_fetch_queue_if.slave bus
);
  localparam int FAW = $clog2(DEPTH);
  localparam int FCW = $clog2(DEPTH + 1);
  localparam int PAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OCW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_ent_t;

  ifq_ent_t        fifo_q [DEPTH];
  logic [XLEN-1:0] ppc_q  [MAX_OUT];
  logic [FAW-1:0]  frd_q, frd_d, fwr_q, fwr_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [PAW-1:0]  prd_q, prd_d, pwr_q, pwr_d;
  logic [OCW-1:0]  out_q, out_d, disc_q, disc_d;
  logic [FCW:0]    used;
  logic            space, accept, rsp, keep, push, pop;

  function automatic logic [PAW-1:0] pinc(input logic [PAW-1:0] p);
    return (p == PAW'(MAX_OUT - 1)) ? '0 : p + PAW'(1);
  endfunction

  // Outstanding requests reserve FIFO slots, so responses always find room.
  always_comb begin
    used  = (FCW+1)'(out_q) + (FCW+1)'(fcnt_q);
    space = (used < (FCW+1)'(DEPTH)) && (out_q < OCW'(MAX_OUT));
  end

  assign bus.imem_req  = bus.pc_valid && space && !bus.flush;
  assign bus.imem_addr = bus.pc_addr;
  assign accept        = bus.imem_req && bus.imem_gnt;
  assign bus.pc_ready  = accept;
  assign rsp           = bus.imem_rvalid && (out_q != '0);
  assign keep          = rsp && (disc_q == '0) && !bus.flush;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp          = keep && (fcnt_q == '0);
  assign bus.if_valid = (fcnt_q != '0) || byp;
  assign bus.if_pc    = byp ? ppc_q[prd_q] : fifo_q[frd_q].pc;
  assign bus.if_instr = byp ? bus.imem_rdata : fifo_q[frd_q].instr;
  assign push         = keep && !(byp && bus.if_ready);
`else
  assign bus.if_valid = fcnt_q != '0;
  assign bus.if_pc    = fifo_q[frd_q].pc;
  assign bus.if_instr = fifo_q[frd_q].instr;
  assign push         = keep;
`endif
  assign pop = (fcnt_q != '0) && bus.if_ready && !bus.flush;

  always_comb begin
    out_d  = out_q + OCW'(accept) - OCW'(rsp);
    disc_d = disc_q;
    // Every request still in flight after a redirect belongs to the old path.
    if (bus.flush)                 disc_d = out_d;
    else if (rsp && disc_q != '0)  disc_d = disc_q - OCW'(1);
    pwr_d  = accept ? pinc(pwr_q) : pwr_q;
    prd_d  = rsp    ? pinc(prd_q) : prd_q;
    frd_d  = frd_q;
    fwr_d  = fwr_q;
    fcnt_d = fcnt_q;
    if (bus.flush) begin
      frd_d  = '0;
      fwr_d  = '0;
      fcnt_d = '0;
    end else begin
      if (push) fwr_d = fwr_q + FAW'(1);
      if (pop)  frd_d = frd_q + FAW'(1);
      fcnt_d = fcnt_q + FCW'(push) - FCW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frd_q  <= '0;
      fwr_q  <= '0;
      fcnt_q <= '0;
      prd_q  <= '0;
      pwr_q  <= '0;
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      frd_q  <= frd_d;
      fwr_q  <= fwr_d;
      fcnt_q <= fcnt_d;
      prd_q  <= prd_d;
      pwr_q  <= pwr_d;
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++)   fifo_q[i] <= '0;
      for (int i = 0; i < MAX_OUT; i++) ppc_q[i]  <= '0;
    end else begin
      if (push)   fifo_q[fwr_q] <= '{pc: ppc_q[prd_q], instr: bus.imem_rdata};
      if (accept) ppc_q[pwr_q]  <= bus.pc_addr;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: grants feed an address queue, kept responses
// feed the expected {pc,instr} queue, which is checked on every decode handshake.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] gq [$];
  logic [63:0] sb [$];
  logic [31:0] dat [3] = '{32'h13, 32'h93, 32'h113};

  instr_fetch_queue_if #(.XLEN(32)) bus ();

  instr_fetch_queue #(.DEPTH(4), .MAX_OUT(2), .XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.pc_ready) gq.push_back(bus.imem_addr);
    if (rstn && !bus.flush && bus.if_valid && bus.if_ready) begin
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("if_pc", bus.if_pc, e[63:32]);
        chk("if_instr", bus.if_instr, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic drive_rsp(input logic [31:0] d, input bit keep);
    logic [31:0] pc;
    if (gq.size() == 0) begin
      chk("rsp_without_grant", 0, 1);
      return;
    end
    pc = gq.pop_front();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = d;
    if (keep) sb.push_back({pc, d});
  endtask

  task automatic mem_tick();
    if (gq.size() > 0) drive_rsp(gq[0] ^ 32'h5A00_0000, 1'b1);
  endtask

  task automatic drain();
    int b = 0;
    bus.pc_valid = 1'b0;
    bus.if_ready = 1'b1;
    while ((sb.size() > 0 || gq.size() > 0) && b < 50) begin
      mem_tick();
      step();
      b++;
    end
    step();
    chk("drain_sb", sb.size(), 0);
    chk("drain_gq", gq.size(), 0);
    chk("drain_idle", bus.if_valid, 0);
  endtask

  initial begin
    int ng;
    rstn = 1'b0;
    bus.pc_valid = 0; bus.pc_addr = 0; bus.flush = 0; bus.imem_gnt = 1;
    bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.if_ready = 1;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_rdy", bus.pc_ready, 0);
    chk("rst_valid", bus.if_valid, 0);
    chk("rst_pc", bus.if_pc, 0);
    chk("rst_instr", bus.if_instr, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // stream of three fetches against a 1-cycle memory
    for (int i = 0; i < 5; i++) begin
      bus.pc_valid = (i < 3);
      bus.pc_addr  = 32'(4 * i);
      if (i >= 1 && i <= 3) drive_rsp(dat[i-1], 1'b1);
      #1;
      if (i == 0) begin
        chk("st_req", bus.imem_req, 1);
        chk("st_addr", bus.imem_addr, 0);
        chk("st_rdy", bus.pc_ready, 1);
      end
`ifndef IFQ_BYPASS_EN
      if (i >= 2) begin
        chk("st_lat_v", bus.if_valid, 1);
        chk("st_lat_pc", bus.if_pc, 32'(4 * (i - 2)));
      end
`endif
      step();
    end
    drain();

    // backpressure: decode stalled, credits run out at DEPTH entries
    ng = 0;
    bus.if_ready = 1'b0;
    bus.pc_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.pc_addr = 32'h200 + 32'(4 * ng);
      mem_tick();
      #1;
      if (bus.pc_ready) ng++;
      step();
    end
    chk("bp_grants", ng, 4);
    chk("bp_rdy", bus.pc_ready, 0);
    chk("bp_req", bus.imem_req, 0);
    bus.if_ready = 1'b1;
    step();
    #1 chk("bp_resume", bus.imem_req, 1);
    step();
    drain();

    // flush with two requests in flight and one buffered entry
    bus.if_ready = 1'b0; bus.pc_valid = 1'b1; bus.pc_addr = 32'h2F0;
    step();
    drive_rsp(32'h77, 1'b0); bus.pc_addr = 32'h300;
    step();
    bus.pc_addr = 32'h304;
    step();
    bus.flush = 1'b1;
    #1;
    chk("fl_req", bus.imem_req, 0);
    chk("fl_rdy", bus.pc_ready, 0);
    step();
    bus.pc_valid = 1'b0;
    chk("fl_empty", bus.if_valid, 0);
    drive_rsp(32'hDEAD, 1'b0);
    step();
    chk("fl_drop0", bus.if_valid, 0);
    drive_rsp(32'hBEEF, 1'b0);
    step();
    chk("fl_drop1", bus.if_valid, 0);
    bus.if_ready = 1'b1; bus.pc_valid = 1'b1; bus.pc_addr = 32'h100;
    #1 chk("fl_refetch", bus.pc_ready, 1);
    step();
    bus.pc_valid = 1'b0;
    drive_rsp(32'h33, 1'b1);
    step();
    drain();

    // flush coinciding with a response and a pop
    bus.if_ready = 1'b0; bus.pc_valid = 1'b1; bus.pc_addr = 32'h400;
    step();
    drive_rsp(32'h55, 1'b0); bus.pc_addr = 32'h404;
    step();
    bus.pc_valid = 1'b0; bus.if_ready = 1'b1; bus.flush = 1'b1;
    drive_rsp(32'hAA, 1'b0);
    step();
    chk("fx_valid", bus.if_valid, 0);
    bus.pc_valid = 1'b1; bus.pc_addr = 32'h500;
    #1 chk("fx_req", bus.imem_req, 1);
    step();
    bus.pc_valid = 1'b0;
    drive_rsp(32'h66, 1'b1);
    step();
    drain();

`ifdef IFQ_BYPASS_EN
    bus.if_ready = 1'b1; bus.pc_valid = 1'b1; bus.pc_addr = 32'h40;
    step();
    bus.pc_valid = 1'b0;
    drive_rsp(32'h13, 1'b1);
    #1;
    chk("byp_valid", bus.if_valid, 1);
    chk("byp_pc", bus.if_pc, 32'h40);
    chk("byp_instr", bus.if_instr, 32'h13);
    step();
    chk("byp_nofifo", bus.if_valid, 0);
    drain();
`endif

    // reset mid-operation with buffered entries and a request in flight
    bus.if_ready = 1'b0; bus.pc_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.pc_addr = 32'h700 + 32'(4 * c);
      mem_tick();
      step();
    end
    chk("mr_pre_valid", bus.if_valid, 1);
    #2;
    rstn = 1'b0; bus.pc_valid = 1'b0;
    #1;
    chk("mr_req", bus.imem_req, 0);
    chk("mr_rdy", bus.pc_ready, 0);
    chk("mr_valid", bus.if_valid, 0);
    chk("mr_pc", bus.if_pc, 0);
    chk("mr_instr", bus.if_instr, 0);
    sb.delete();
    gq.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    bus.if_ready = 1'b1; bus.pc_valid = 1'b1; bus.pc_addr = 32'h600;
    #1 chk("mr_reissue", bus.pc_ready, 1);
    step();
    bus.pc_valid = 1'b0;
    drive_rsp(32'h99, 1'b1);
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
